bp_be_issue_buffer: RTL

- Replayable circular instruction buffer feeding the backend dependency/hazard checker.
- Accepts decoded fetch entries from the frontend queue and presents the oldest unissued entry as the issue packet.
- Pops the entry when the checker dispatches it.
- Keeps every issued-but-uncommitted entry, so a rollback re-issues from the oldest uncommitted entry and a flush discards all entries.

---
 rtl/bp_be_issue_buffer.sv | 108 ++++++++++
 1 files changed

// File: rtl/bp_be_issue_buffer.sv
// bp_be_issue_buffer: replayable circular buffer between the frontend queue and
// the backend dependency/hazard checker. Three pointers (write, issue, commit),
// each carrying an extra wrap bit, track the occupied, issued and uncommitted
// regions. A rollback rewinds the issue pointer to the oldest uncommitted entry.
// Optional build macro: BP_BE_ISSUE_BYPASS_EN -- when defined, an entry arriving
// at an empty issue point is presented on the issue port in the same cycle.
module bp_be_issue_buffer #(
   parameter int els_p         = 16,
   parameter int entry_width_p = 128,
   localparam int ptr_width_lp = $clog2(els_p)
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     enq_v_i,
   input  logic [entry_width_p-1:0] enq_data_i,
   output logic                     enq_ready_o,
   output logic                     issue_v_o,
   output logic [entry_width_p-1:0] issue_data_o,
   input  logic                     deq_yumi_i,
   input  logic                     cmt_v_i,
   input  logic                     roll_i,
   input  logic                     clr_i,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam logic [ptr_width_lp:0] one_lp = (ptr_width_lp+1)'(1);

   logic [ptr_width_lp:0]      wptr_q, wptr_d;
   logic [ptr_width_lp:0]      rptr_q, rptr_d;
   logic [ptr_width_lp:0]      cptr_q, cptr_d;
   logic [ptr_width_lp:0]      cptr_inc;
   logic [entry_width_p-1:0]   mem_q [els_p];
   logic [ptr_width_lp-1:0]    widx, ridx, cidx;
   logic                       enq_fire;
   logic                       stored_v;

   assign widx = wptr_q[ptr_width_lp-1:0];
   assign ridx = rptr_q[ptr_width_lp-1:0];
   assign cidx = cptr_q[ptr_width_lp-1:0];

   // Occupancy is measured from the commit pointer: issued entries still hold space
   assign full_o      = (widx == cidx) && (wptr_q[ptr_width_lp] != cptr_q[ptr_width_lp]);
   assign empty_o     = (wptr_q == cptr_q);
   assign enq_ready_o = ~full_o & ~reset_i;
   assign enq_fire    = enq_v_i & enq_ready_o & ~clr_i;
   assign stored_v    = (rptr_q != wptr_q);

`ifdef BP_BE_ISSUE_BYPASS_EN
   logic bypass_v;

   // Forward an arriving entry straight to the checker when nothing older is pending
   assign bypass_v     = ~stored_v & enq_v_i & enq_ready_o;
   assign issue_v_o    = (stored_v | bypass_v) & ~roll_i & ~clr_i;
   assign issue_data_o = stored_v ? mem_q[ridx] : enq_data_i;
`else
   // Entries become visible one cycle after they are written
   assign issue_v_o    = stored_v & ~roll_i & ~clr_i;
   assign issue_data_o = mem_q[ridx];
`endif

   // Next-pointer computation: flush beats rollback beats dequeue
   always_comb begin
      cptr_inc = cmt_v_i ? (cptr_q + one_lp) : cptr_q;
      wptr_d   = enq_fire ? (wptr_q + one_lp) : wptr_q;
      cptr_d   = cptr_inc;
      rptr_d   = rptr_q;
      if (roll_i) begin
         rptr_d = cptr_inc;
      end else if (deq_yumi_i) begin
         rptr_d = rptr_q + one_lp;
      end
      if (clr_i) begin
         wptr_d = '0;
         rptr_d = '0;
         cptr_d = '0;
      end
   end

   // Pointer registers
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cptr_q <= cptr_d;
      end
   end

   // Entry storage: synchronous write, contents deliberately left unreset
   always_ff @(posedge clk_i) begin
      if (enq_fire) begin
         mem_q[widx] <= enq_data_i;
      end
   end

   // Protocol checks: no commit past the issue point, no dispatch of an invalid head
   always_ff @(posedge clk_i) begin
      if (!reset_i && !clr_i) begin
         assert (!(cmt_v_i && (cptr_q == rptr_q)));
         assert (!(deq_yumi_i && !roll_i && !issue_v_o));
      end
   end

endmodule
